mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the 32-bit MIPS datapath.
- Sits directly downstream of the register file and consumes its two read ports (rs value, rt value).
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in architectural HI/LO registers.
- Also services MTHI/MTLO writes. HI/LO feed MFHI/MFLO through the writeback mux.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits, and the iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch request; sampled on the rising edge only when busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_val  in  WIDTH  operand A / dividend, from register file read port 1.
- rt_val  in  WIDTH  operand B / divisor, from register file read port 2.
- hi_wr  in  1  MTHI strobe.
- lo_wr  in  1  MTLO strobe.
- wdata  in  WIDTH  data for MTHI/MTLO.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when hi/lo take a new result.

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0; iteration counter and internal accumulators cleared.
- Reset mid-operation aborts the operation: no result is written and done does not pulse.
- States:
  - IDLE: busy=0.
  - CALC: busy=1; one iteration per clock; 6-bit counter 0..WIDTH-1.
  - FIX: busy=1; sign correction and HI/LO writeback.
- IDLE -> CALC on the edge sampling start=1.
  - rs_val, rt_val and op are latched on that edge; later changes on the register file ports are ignored.
  - Signed ops latch operand magnitudes and record sign flags.
- CALC: exactly WIDTH iterations; on the edge completing iteration WIDTH-1, go to FIX.
- FIX -> IDLE on the next edge.
  - hi/lo are written on this edge.
  - done=1 for the following cycle only.
  - busy=0 from the same cycle.
- Latency, with start sampled at edge E0:
  - busy is high for cycles E0..E33, i.e. 33 cycles.
  - hi/lo update at E33; done is high during cycle E33..E34.
- Multiply: unsigned shift-add on magnitudes giving a 2*WIDTH product; {hi,lo} = product.
  - MULT negates the full 2*WIDTH product when the operand signs differ.
- Divide: restoring division on magnitudes; lo = quotient, hi = remainder.
  - DIV truncates the quotient toward zero.
  - DIV negates the quotient when the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (rt_val=0), DIV or DIVU: same 33-cycle latency; hi = latched rs_val, lo = all ones; done pulses normally.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy=1 is ignored (not queued), including during FIX.
- hi_wr/lo_wr in IDLE write wdata to hi/lo on that edge.
- hi_wr/lo_wr while busy are ignored.
- hi_wr/lo_wr together with an accepted start: the MTHI/MTLO write occurs; the result later overwrites it.
- op values are ignored unless start is accepted.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start 1 cycle -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly 1 cycle.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=7; change rs_val/rt_val to 0 one cycle after start -> lo=14, hi=2 (operands latched). DIVU rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF after 33 cycles.
- Second start pulsed at cycles 5 and 33 of a busy MULTU -> ignored, result unchanged, a single done pulse. hi_wr with wdata=0x1234 while busy -> hi unaffected.
- In IDLE: hi_wr wdata=0xA5A5A5A5, then lo_wr wdata=0x5A5A5A5A -> hi/lo updated next edge, no done pulse.
- rst asserted asynchronously mid-CALC (cycle 10 of DIV) -> immediately hi=0, lo=0, busy=0, done=0; no done after release; a new start runs a correct full 33-cycle operation.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Bundle between the register-file read ports / writeback mux and the
// iterative multiply/divide unit: launch, operands, MTHI/MTLO, HI/LO results.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_wr;
    logic             lo_wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs_val, rt_val, hi_wr, lo_wr, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_val, rt_val, hi_wr, lo_wr, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// One shift-add or restoring-divide step per clock on operand magnitudes.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    mult_div_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [5:0]         r_cnt;
    logic               r_is_div;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_start;
    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_start  = (r_state == S_IDLE) && bus.start;
    assign w_signed = ~bus.op[0];
    assign w_neg_a  = w_signed & bus.rs_val[WIDTH-1];
    assign w_neg_b  = w_signed & bus.rt_val[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~bus.rs_val + 1'b1) : bus.rs_val;
    assign w_mag_b  = w_neg_b ? (~bus.rt_val + 1'b1) : bus.rt_val;

    // Multiply: upper half accumulates, multiplier bits drain out of the low half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, low half shifts dividend out / quotient in.
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = w_rem_sh >= {1'b0, r_opnd};
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
    assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_div_zero ? '1
                      : ((r_neg_a ^ r_neg_b) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0]);
    // Remainder follows the dividend sign; with a zero divisor this restores rs_val.
    assign w_rem_fix  = r_neg_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_wr) r_hi <= bus.wdata;
                    if (bus.lo_wr) r_lo <= bus.wdata;
                    if (w_start) begin
                        r_state    <= S_CALC;
                        r_cnt      <= '0;
                        r_is_div   <= bus.op[1];
                        r_neg_a    <= w_neg_a;
                        r_neg_b    <= w_neg_b;
                        r_div_zero <= bus.op[1] && (bus.rt_val == '0);
                        r_opnd     <= w_mag_b;
                        r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
endmodule
